// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive deframer.
//   rx_state_e       : deframer FSM states
//   MII_*_NIB        : preamble / start-of-frame-delimiter nibble values
//   ST_*             : bit positions inside the 3-bit frame status word
package mii_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_e;

  localparam logic [3:0] MII_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] MII_SFD_NIB      = 4'hD;

  localparam int ST_RXER     = 0;
  localparam int ST_DRIBBLE  = 1;
  localparam int ST_OVERSIZE = 2;

endpackage

// File: rtl/mii_nibble_packer.sv
// Packs MII nibbles low-nibble-first into bytes.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart at phase 0 (start of payload)
//   en         : a payload nibble is present on nib this cycle
//   nib        : incoming nibble
//   byte_data  : {nib, stored low nibble}; meaningful when byte_done=1
//   byte_done  : high nibble of a byte is being accepted this cycle
//   phase      : 1 when a low nibble is stored and waiting for its partner
module mii_nibble_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] nib,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       phase
);

  logic [3:0] low_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= 1'b0;
      low_q <= 4'h0;
    end else if (en) begin
      if (!phase) low_q <= nib;
      phase <= ~phase;
    end
  end

  // The byte is formed combinationally on the edge the high nibble arrives.
  assign byte_data = {nib, low_q};
  assign byte_done = en & phase;

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes and
// emits a byte stream with end-of-frame length/status plus good/bad counters.
//   phy_rx_clk, phy_rst            : clock, synchronous active-high reset
//   phy_rxd, phy_rx_dv, phy_rx_er  : MII receive pins
//   m_data, m_valid, m_last        : byte stream, single-cycle pulses, no backpressure
//   m_status                       : {oversize, dribble, rx_er}, updated with m_last
//   frame_len                      : byte count, updated with m_last
//   good_frames, bad_frames        : saturating frame counters
module mii_rx_deframer import mii_pkg::*; #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int PREAMBLE_MIN    = 2,
  parameter int CNT_W           = 16
) (
  input  logic             phy_rx_clk,
  input  logic             phy_rst,
  input  logic [3:0]       phy_rxd,
  input  logic             phy_rx_dv,
  input  logic             phy_rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic [2:0]       m_status,
  output logic [CNT_W-1:0] frame_len,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames
);

  localparam logic [7:0]       PCNT_MIN = 8'(PREAMBLE_MIN);
  localparam logic [7:0]       PCNT_SAT = 8'hFF;
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] LEN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_state_e        state_q, state_d;
  logic             dv_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             er_q, er_d;
  logic [7:0]       hold_q, hold_d;

  logic             emit, emit_last, good_inc, bad_inc;
  logic [2:0]       status_d;

  logic             pk_clr, pk_en, pk_done, pk_phase;
  logic [7:0]       pk_byte;

  mii_nibble_packer u_packer (
    .clk       (phy_rx_clk),
    .rst       (phy_rst),
    .clr       (pk_clr),
    .en        (pk_en),
    .nib       (phy_rxd),
    .byte_data (pk_byte),
    .byte_done (pk_done),
    .phase     (pk_phase)
  );

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    len_d     = len_q;
    er_d      = er_q;
    hold_d    = hold_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    status_d  = 3'b000;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    pk_clr    = 1'b0;
    pk_en     = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a rising dv starts a frame; dv_d resets high so a frame
        // already in flight at reset release is skipped entirely.
        if (phy_rx_dv && !dv_d) begin
          if (phy_rxd == MII_PREAMBLE_NIB) begin
            state_d = PRE;
            pcnt_d  = 8'd1;
          end else begin
            state_d = DROP;
            bad_inc = 1'b1;
          end
        end
      end

      PRE: begin
        if (!phy_rx_dv) begin
          state_d = IDLE;
          bad_inc = 1'b1;
        end else if (phy_rxd == MII_PREAMBLE_NIB) begin
          if (pcnt_q != PCNT_SAT) pcnt_d = pcnt_q + 8'd1;
        end else if (phy_rxd == MII_SFD_NIB && pcnt_q >= PCNT_MIN) begin
          state_d = DATA;
          pk_clr  = 1'b1;
          len_d   = '0;
          er_d    = 1'b0;
        end else begin
          state_d = DROP;
          bad_inc = 1'b1;
        end
      end

      DATA: begin
        if (phy_rx_dv) begin
          pk_en = 1'b1;
          er_d  = er_q | phy_rx_er;
          if (pk_done) begin
            if (len_q == LEN_MAX) begin
              // One byte too many: close the frame on the held byte and
              // discard the rest of it.
              emit                  = 1'b1;
              emit_last             = 1'b1;
              status_d[ST_OVERSIZE] = 1'b1;
              status_d[ST_RXER]     = er_d;
              bad_inc               = 1'b1;
              state_d               = DROP;
            end else begin
              // Held byte goes out only once its successor exists, so the
              // final byte can still be tagged m_last at end of frame.
              emit   = (len_q != '0);
              hold_d = pk_byte;
              len_d  = len_q + LEN_ONE;
            end
          end
        end else begin
          state_d = IDLE;
          if (len_q == '0) begin
            bad_inc = 1'b1;
          end else begin
            emit                 = 1'b1;
            emit_last            = 1'b1;
            status_d[ST_DRIBBLE] = pk_phase;
            status_d[ST_RXER]    = er_q;
            good_inc             = !(pk_phase || er_q);
            bad_inc              = pk_phase || er_q;
          end
        end
      end

      DROP: begin
        if (!phy_rx_dv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_rx_clk) begin
    if (phy_rst) begin
      state_q     <= IDLE;
      dv_d        <= 1'b1;
      pcnt_q      <= '0;
      len_q       <= '0;
      er_q        <= 1'b0;
      hold_q      <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_status    <= '0;
      frame_len   <= '0;
      good_frames <= '0;
      bad_frames  <= '0;
    end else begin
      state_q <= state_d;
      dv_d    <= phy_rx_dv;
      pcnt_q  <= pcnt_d;
      len_q   <= len_d;
      er_q    <= er_d;
      hold_q  <= hold_d;
      m_valid <= emit;
      m_last  <= emit_last;
      if (emit) m_data <= hold_q;
      if (emit_last) begin
        m_status  <= status_d;
        frame_len <= len_q;
      end
      if (good_inc && good_frames != '1) good_frames <= good_frames + LEN_ONE;
      if (bad_inc && bad_frames != '1)   bad_frames  <= bad_frames + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer: table of directed frames, a hand-written
// reset-mid-frame sequence, and random frames scored against a frame-level
// reference model that parses the nibble list directly.
module tb_mii_rx_deframer;

  localparam int MAXB = 64;
  localparam int CW   = 16;
  localparam int PMIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    rxd = 4'h0;
  logic          dv  = 1'b0;
  logic          er  = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid, m_last;
  logic [2:0]    m_status;
  logic [CW-1:0] frame_len, good_frames, bad_frames;

  always #5 clk = ~clk;

  mii_rx_deframer #(.MAX_FRAME_BYTES(MAXB), .PREAMBLE_MIN(PMIN), .CNT_W(CW)) dut (
    .phy_rx_clk (clk),
    .phy_rst    (rst),
    .phy_rxd    (rxd),
    .phy_rx_dv  (dv),
    .phy_rx_er  (er),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_status   (m_status),
    .frame_len  (frame_len),
    .good_frames(good_frames),
    .bad_frames (bad_frames)
  );

  typedef struct {
    logic [7:0] d;
    bit         last;
    logic [2:0] st;
    int         len;
  } exp_t;

  typedef struct {
    int         pre;      // count of 0x5 nibbles
    int         sfd;      // nibble after the preamble
    int         nb;       // payload bytes
    bit         odd;      // append one dribble nibble 0xA
    int         er_byte;  // byte index carrying phy_rx_er, -1 none
    int         gap;      // dv-low cycles after the frame; 1 = no check
    int         exp_n;    // m_valid count since the previous check
    logic [2:0] exp_st;
    int         exp_len;
    int         dgood;
    int         dbad;
  } vec_t;

  exp_t       exp_q[$];
  logic [3:0] nq[$];
  bit         eq[$];
  int         vectors = 0, errors = 0;
  int         good_exp = 0, bad_exp = 0;
  int         obs_cnt = 0, obs_len = 0;
  logic [2:0] obs_st = 3'b000;
  bit         ignore = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Output monitor: every emitted byte is matched against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!ignore && !rst) begin
      if (m_last) chk("last_needs_valid", m_valid, 1);
      if (m_valid) begin
        obs_cnt++;
        if (m_last) begin
          obs_st  = m_status;
          obs_len = frame_len;
        end
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, required no output", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.d);
          chk("last", m_last, e.last);
          if (e.last) begin
            chk("status", m_status, e.st);
            chk("frame_len", frame_len, e.len);
          end
        end
      end
    end
  end

  task automatic build(input int pre, input int sfd, input int nb, input bit odd,
                       input int er_byte, input bit rnd);
    logic [7:0] b8;
    nq.delete();
    eq.delete();
    for (int i = 0; i < pre; i++) begin nq.push_back(4'h5); eq.push_back(1'b0); end
    if (sfd >= 0) begin nq.push_back(4'(sfd)); eq.push_back(1'b0); end
    for (int b = 0; b < nb; b++) begin
      b8 = rnd ? 8'($urandom) : 8'(b + 1);
      nq.push_back(b8[3:0]); eq.push_back(1'b0);
      nq.push_back(b8[7:4]); eq.push_back(b == er_byte);
    end
    if (odd) begin nq.push_back(4'hA); eq.push_back(1'b0); end
  endtask

  // Frame-level reference: parse preamble/SFD, pair payload nibbles,
  // truncate at MAXB, derive status and which counter moves.
  task automatic model();
    int   n, p, start, pn, full, nout;
    bit   erf, odd;
    exp_t e;
    n = nq.size();
    if (n == 0) return;
    p = 0;
    while (p < n && nq[p] == 4'h5) p++;
    if (p == 0 || p == n || nq[p] != 4'hD || p < PMIN) begin
      bad_exp++;
      return;
    end
    start = p + 1;
    pn    = n - start;
    full  = pn / 2;
    odd   = (pn % 2) == 1;
    erf   = 1'b0;
    if (full > MAXB) begin
      for (int i = start; i < start + 2 * MAXB + 2; i++) erf |= eq[i];
      nout = MAXB;
    end else begin
      for (int i = start; i < n; i++) erf |= eq[i];
      nout = full;
    end
    if (nout == 0) begin
      bad_exp++;
      return;
    end
    for (int k = 0; k < nout; k++) begin
      e.d    = {nq[start + 2 * k + 1], nq[start + 2 * k]};
      e.last = (k == nout - 1);
      e.st   = (full > MAXB) ? {1'b1, 1'b0, erf} : {1'b0, odd, erf};
      e.len  = e.last ? nout : 0;
      if (!e.last) e.st = 3'b000;
      exp_q.push_back(e);
    end
    if (full <= MAXB && !odd && !erf) good_exp++;
    else bad_exp++;
  endtask

  task automatic send(input int gap);
    for (int i = 0; i < nq.size(); i++) begin
      @(posedge clk); #1;
      dv = 1'b1; rxd = nq[i]; er = eq[i];
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      dv = 1'b0; er = 1'b0; rxd = 4'($urandom);
    end
  endtask

  vec_t tbl[13];
  int   tgood, tbad;

  initial begin
    tbl[0]  = '{15, 13, 64, 0, -1, 3, 64, 3'b000, 64, 1, 0};  // clean 64-byte frame
    tbl[1]  = '{15, 13, 64, 0,  9, 3, 64, 3'b001, 64, 0, 1};  // rx_er in byte 10
    tbl[2]  = '{15, 13, 20, 1, -1, 3, 20, 3'b010, 20, 0, 1};  // dribble nibble
    tbl[3]  = '{ 2,  7,  8, 0, -1, 3,  0, 3'b000,  0, 0, 1};  // 5,5,7 preamble
    tbl[4]  = '{ 1, 13,  8, 0, -1, 3,  0, 3'b000,  0, 0, 1};  // SFD after one 5
    tbl[5]  = '{ 7, 13, 10, 0, -1, 3, 10, 3'b000, 10, 1, 0};  // recovers
    tbl[6]  = '{ 7, 13, 70, 0, -1, 3, 64, 3'b100, 64, 0, 1};  // oversize
    tbl[7]  = '{ 7, 13, 10, 0, -1, 3, 10, 3'b000, 10, 1, 0};  // good after oversize
    tbl[8]  = '{ 7, 13,  0, 0, -1, 3,  0, 3'b000,  0, 0, 1};  // zero payload
    tbl[9]  = '{ 2, 13,  1, 0, -1, 3,  1, 3'b000,  1, 1, 0};  // minimum preamble, 1 byte
    tbl[10] = '{ 0, 13,  5, 0, -1, 3,  0, 3'b000,  0, 0, 1};  // first nibble not 5
    tbl[11] = '{ 7, 13, 12, 0, -1, 1,  0, 3'b000,  0, 0, 0};  // back-to-back, 1 idle
    tbl[12] = '{ 7, 13, 12, 0, -1, 3, 24, 3'b000, 12, 2, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_status", m_status, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_good", good_frames, 0);
    chk("rst_bad", bad_frames, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table
    tgood = 0; tbad = 0;
    for (int r = 0; r < 13; r++) begin
      build(tbl[r].pre, tbl[r].sfd, tbl[r].nb, tbl[r].odd, tbl[r].er_byte, 1'b0);
      model();
      send(tbl[r].gap);
      tgood += tbl[r].dgood;
      tbad  += tbl[r].dbad;
      if (tbl[r].gap >= 2) begin
        @(negedge clk); #1;
        chk($sformatf("row%0d_pending", r), exp_q.size(), 0);
        chk($sformatf("row%0d_nbytes", r), obs_cnt, tbl[r].exp_n);
        if (tbl[r].exp_n > 0) begin
          chk($sformatf("row%0d_status", r), obs_st, tbl[r].exp_st);
          chk($sformatf("row%0d_len", r), obs_len, tbl[r].exp_len);
        end
        chk($sformatf("row%0d_good", r), good_frames, tgood);
        chk($sformatf("row%0d_bad", r), bad_frames, tbad);
        obs_cnt = 0;
      end
    end

    // Reset pulsed mid-payload and released while dv stays high
    build(7, 13, 30, 0, -1, 1'b0);
    ignore = 1'b1;
    for (int i = 0; i < nq.size(); i++) begin
      @(posedge clk); #1;
      if (i == 43) begin
        ignore  = 1'b0;
        obs_cnt = 0;
        exp_q.delete();
        chk("midrst_valid", m_valid, 0);
        chk("midrst_len", frame_len, 0);
        chk("midrst_good", good_frames, 0);
        chk("midrst_bad", bad_frames, 0);
      end
      rst = (i >= 40 && i < 43);
      dv = 1'b1; rxd = nq[i]; er = eq[i];
    end
    send(3);
    @(negedge clk); #1;
    chk("midrst_no_output", obs_cnt, 0);
    chk("midrst_no_count_good", good_frames, 0);
    chk("midrst_no_count_bad", bad_frames, 0);
    good_exp = 0; bad_exp = 0;
    build(7, 13, 10, 0, -1, 1'b0);
    model();
    send(3);
    @(negedge clk); #1;
    chk("postrst_nbytes", obs_cnt, 10);
    chk("postrst_good", good_frames, 1);
    obs_cnt = 0;

    // Random frames against the reference model
    for (int r = 0; r < 40; r++) begin
      build(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 12),
            ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : 13,
            $urandom_range(0, 72), $urandom_range(0, 3) == 0, -1, 1'b1);
      for (int i = 0; i < eq.size(); i++) eq[i] = ($urandom_range(0, 49) == 0);
      model();
      send($urandom_range(2, 4));
      @(negedge clk); #1;
      chk($sformatf("rnd%0d_pending", r), exp_q.size(), 0);
      chk($sformatf("rnd%0d_good", r), good_frames, good_exp);
      chk($sformatf("rnd%0d_bad", r), bad_frames, bad_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
